// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - frame-coherent common-anode 7-seg scanner; optional LEADING_ZERO_BLANK_EN
module seven_segment_scan #(
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int SCAN_FREQUENCY_IN_HZ        = 1_000,
    parameter int BLINK_FREQUENCY_IN_HZ       = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
    input  logic [NUMBER_OF_DIGITS-1:0]                          blink_mask,
    input  logic                                                 enable,
    output logic [NUMBER_OF_DIGITS-1:0]                          an,
    output logic [6:0]                                           seg,
    output logic                                                 frame_start
);

    localparam int DW           = NUMBER_OF_BITS_PER_DIGIT;
    localparam int NUM_W        = NUMBER_OF_DIGITS * DW;
    localparam int SCAN_DIVIDE  = BOARD_CLOCK_FREQUENCY_IN_HZ / SCAN_FREQUENCY_IN_HZ;
    localparam int BLINK_DIVIDE = BOARD_CLOCK_FREQUENCY_IN_HZ / (2 * BLINK_FREQUENCY_IN_HZ);
    localparam int SCAN_W       = (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;
    localparam int BLINK_W      = (BLINK_DIVIDE > 1) ? $clog2(BLINK_DIVIDE) : 1;
    localparam int IDX_W        = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;

    logic [SCAN_W-1:0]           scan_cnt;
    logic [BLINK_W-1:0]          blink_cnt;
    logic                        blink_phase;
    logic [IDX_W-1:0]            idx;
    logic [NUM_W-1:0]            shadow_number;
    logic [NUMBER_OF_DIGITS-1:0] shadow_mask;
    logic                        load_pending;

    logic                        scan_tick;
    logic                        blink_tick;
    logic                        idx_last;
    logic                        load;
    logic [DW-1:0]               cur_digit;
    logic                        cur_mask;
    logic                        cur_lz;
    logic [NUMBER_OF_DIGITS-1:0] an_next;
    logic [NUMBER_OF_DIGITS-1:0] lz_blank;
    logic                        blank;

    assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIVIDE - 1));
    assign blink_tick = (blink_cnt == BLINK_W'(BLINK_DIVIDE - 1));
    assign idx_last   = (idx == IDX_W'(NUMBER_OF_DIGITS - 1));
    assign load       = load_pending || (scan_tick && idx_last);

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] decode(input logic [DW-1:0] d);
        case (int'(d))
            0:       decode = 7'h40;
            1:       decode = 7'h79;
            2:       decode = 7'h24;
            3:       decode = 7'h30;
            4:       decode = 7'h19;
            5:       decode = 7'h12;
            6:       decode = 7'h02;
            7:       decode = 7'h78;
            8:       decode = 7'h00;
            9:       decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Slot prescaler, digit index and once-per-frame snapshot of the digit bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt      <= '0;
            idx           <= '0;
            shadow_number <= '0;
            shadow_mask   <= '0;
            load_pending  <= 1'b1;
            frame_start   <= 1'b0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_tick) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            end
            if (load) begin
                shadow_number <= number;
                shadow_mask   <= blink_mask;
            end
            load_pending <= 1'b0;
            frame_start  <= load;
        end
    end

    // Free-running blink half-period counter, independent of the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt <= blink_tick ? '0 : blink_cnt + BLINK_W'(1);
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zeros_above;

    // Digit k>=1 goes dark while it and every more-significant shadow digit are zero.
    always_comb begin
        lz_blank    = '0;
        zeros_above = 1'b1;
        for (int k = NUMBER_OF_DIGITS - 1; k >= 1; k--) begin
            zeros_above = zeros_above & (shadow_number[k*DW +: DW] == '0);
            lz_blank[k] = zeros_above;
        end
    end
`else
    // Leading zeros are displayed like any other digit.
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Select the shadow digit, its blink bit and its anode for the current slot.
    always_comb begin
        cur_digit = '0;
        cur_mask  = 1'b0;
        cur_lz    = 1'b0;
        an_next   = '1;
        for (int k = 0; k < NUMBER_OF_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_digit  = shadow_number[k*DW +: DW];
                cur_mask   = shadow_mask[k];
                cur_lz     = lz_blank[k];
                an_next[k] = 1'b0;
            end
        end
        blank = !enable || (cur_mask && blink_phase) || cur_lz;
    end

    // Registered drive lines; a blanked slot turns every anode and segment off.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
        end else if (blank) begin
            an  <= '1;
            seg <= 7'h7F;
        end else begin
            an  <= an_next;
            seg <= decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - scoreboard bench for seven_segment_scan
module tb_seven_segment_scan;

    typedef struct {
        int         cyc;
        bit         chk_out;
        bit         chk_fs;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] number = 16'h0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic        enable = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    int    cyc = 0;
    int    t0 = 0;
    int    errors = 0;
    int    checks = 0;
    bit    mon_on = 1'b0;
    string scen = "init";

    exp_t       sb[$];
    exp_t       keep[$];
    logic [3:0] exp_an[8];
    logic [6:0] exp_seg[8];

    seven_segment_scan #(
        .NUMBER_OF_DIGITS           (4),
        .NUMBER_OF_BITS_PER_DIGIT   (4),
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .SCAN_FREQUENCY_IN_HZ       (100),
        .BLINK_FREQUENCY_IN_HZ      (25)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .number     (number),
        .blink_mask (blink_mask),
        .enable     (enable),
        .an         (an),
        .seg        (seg),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input bit co, input logic [3:0] a, input logic [6:0] s,
                        input bit cf, input logic f);
        exp_t e;
        e.cyc = c; e.chk_out = co; e.chk_fs = cf;
        e.an = a; e.seg = s; e.fs = f; e.name = scen;
        sb.push_back(e);
    endtask

    // Expected segments for slots 0..3 of frame m; 7F means the slot is dark.
    task automatic set_frame(input int m, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            exp_seg[m*4+k] = s[k];
            exp_an[m*4+k]  = (s[k] == 7'h7F) ? 4'hF : ~(4'b0001 << k);
        end
    endtask

    // Slot j of frame m is on the pins at rel 40m+10j+1..+10; frame_start at rel 1, then every 40.
    task automatic push_scan(input int nrel);
        for (int rel = 1; rel <= nrel; rel++) begin
            int m, k;
            bit co;
            m  = (rel - 1) / 40;
            k  = ((rel - 1) % 40) / 10;
            co = (((rel - 1) % 10) == 5) && (m < 2);
            push(t0 + rel, co, co ? exp_an[m*4+k] : 4'hF, co ? exp_seg[m*4+k] : 7'h7F,
                 1'b1, (rel == 1) || (rel % 40 == 0));
        end
    endtask

    task automatic do_reset(input int n);
        int c;
        rst = 1'b1;
        c = cyc;
        for (int i = 1; i <= n; i++) push(c + i, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_rel(input int r);
        while (cyc < t0 + r) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every scoreboard entry due this cycle, plus the single-anode rule.
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL anode_onehot cyc=%0d an=%b required at most one low", cyc, an);
            end
        end
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].chk_fs) begin
                    checks++;
                    if (frame_start !== sb[i].fs) begin
                        errors++;
                        $display("FAIL %s frame_start cyc=%0d got=%b required=%b",
                                 sb[i].name, cyc - t0, frame_start, sb[i].fs);
                    end
                end
                if (sb[i].chk_out) begin
                    checks++;
                    if (an !== sb[i].an || seg !== sb[i].seg) begin
                        errors++;
                        $display("FAIL %s out rel=%0d got an=%b seg=%h required an=%b seg=%h",
                                 sb[i].name, cyc - t0, an, seg, sb[i].an, sb[i].seg);
                    end
                end
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed cyc=%0d", sb[i].name, sb[i].cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Scan order over two frames.
        scen = "scan_order"; number = 16'h1234; blink_mask = 4'b0000; enable = 1'b1;
        do_reset(3);
        mon_on = 1'b1;
        set_frame(0, 7'h19, 7'h30, 7'h24, 7'h79);
        set_frame(1, 7'h19, 7'h30, 7'h24, 7'h79);
        push_scan(81);
        wait_rel(81);

        // Bus changes during slot 1 only appear in the next frame.
        scen = "coherence"; number = 16'h1234;
        do_reset(2);
        set_frame(0, 7'h19, 7'h30, 7'h24, 7'h79);
        set_frame(1, 7'h00, 7'h78, 7'h02, 7'h12);
        push_scan(81);
        wait_rel(15);
        number = 16'h5678;
        wait_rel(81);

        // Blink phase is 0 behind slots 0,1 and 1 behind slots 2,3 after reset.
        scen = "blink"; number = 16'h1234; blink_mask = 4'b1001;
        do_reset(2);
        set_frame(0, 7'h19, 7'h30, 7'h24, 7'h7F);
        set_frame(1, 7'h19, 7'h30, 7'h24, 7'h7F);
        push_scan(81);
        push(t0 + 30, 1'b1, 4'b1011, 7'h24, 1'b0, 1'b0);
        push(t0 + 31, 1'b1, 4'hF, 7'h7F, 1'b0, 1'b0);
        push(t0 + 11, 1'b1, 4'b1101, 7'h30, 1'b0, 1'b0);
        wait_rel(81);
        blink_mask = 4'b0000;

        // Decode table including dash codes.
        scen = "decode_567A"; number = 16'h567A;
        do_reset(2);
        set_frame(0, 7'h3F, 7'h78, 7'h02, 7'h12);
        set_frame(1, 7'h3F, 7'h78, 7'h02, 7'h12);
        push_scan(41);
        wait_rel(41);

        scen = "decode_890F"; number = 16'h890F;
        do_reset(2);
`ifdef LEADING_ZERO_BLANK_EN
        set_frame(0, 7'h3F, 7'h40, 7'h10, 7'h00);
`else
        set_frame(0, 7'h3F, 7'h40, 7'h10, 7'h00);
`endif
        set_frame(1, 7'h3F, 7'h40, 7'h10, 7'h00);
        push_scan(41);
        wait_rel(41);

        // Display disabled: dark every cycle, frames keep running.
        scen = "enable_off"; number = 16'h1234; enable = 1'b0;
        do_reset(2);
        for (int rel = 1; rel <= 81; rel++)
            push(t0 + rel, 1'b1, 4'hF, 7'h7F, 1'b1, (rel == 1) || (rel % 40 == 0));
        wait_rel(81);
        enable = 1'b1;

        // Reset during slot 2, then a clean restart at slot 0.
        scen = "reset_mid"; number = 16'h1234;
        do_reset(2);
        set_frame(0, 7'h19, 7'h30, 7'h24, 7'h79);
        set_frame(1, 7'h19, 7'h30, 7'h24, 7'h79);
        push_scan(24);
        wait_rel(24);
        do_reset(1);
        scen = "restart";
        push_scan(46);
        wait_rel(46);

        // Leading-zero handling.
        scen = "lz_0005"; number = 16'h0005;
        do_reset(2);
`ifdef LEADING_ZERO_BLANK_EN
        set_frame(0, 7'h12, 7'h7F, 7'h7F, 7'h7F);
        set_frame(1, 7'h12, 7'h7F, 7'h7F, 7'h7F);
`else
        set_frame(0, 7'h12, 7'h40, 7'h40, 7'h40);
        set_frame(1, 7'h12, 7'h40, 7'h40, 7'h40);
`endif
        push_scan(41);
        wait_rel(41);

        scen = "lz_0000"; number = 16'h0000;
        do_reset(2);
`ifdef LEADING_ZERO_BLANK_EN
        set_frame(0, 7'h40, 7'h7F, 7'h7F, 7'h7F);
`else
        set_frame(0, 7'h40, 7'h40, 7'h40, 7'h40);
`endif
        push_scan(40);
        wait_rel(40);

        scen = "lz_0050"; number = 16'h0050;
        do_reset(2);
`ifdef LEADING_ZERO_BLANK_EN
        set_frame(0, 7'h40, 7'h12, 7'h7F, 7'h7F);
`else
        set_frame(0, 7'h40, 7'h12, 7'h40, 7'h40);
`endif
        push_scan(40);
        wait_rel(40);

        repeat (3) @(posedge clk);
        #1;
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never_checked cyc=%0d", sb[i].name, sb[i].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
- Display-side consumer of the packed MM:SS digit bus and per-digit blink selection produced by the digit-setting logic.
- Time-multiplexes NUMBER_OF_DIGITS BCD digits onto one common-anode seven-segment display.
- Snapshots the digit bus once per scan frame so no digit tears mid-frame.
- Blanks blink-selected digits on a blink clock and drives active-low anode and segment lines.

Parameters:
- NUMBER_OF_DIGITS, 4, digits scanned; digit 0 is the rightmost (seconds units).
- NUMBER_OF_BITS_PER_DIGIT, 4, BCD width per digit.
- BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency.
- SCAN_FREQUENCY_IN_HZ, 1_000, per-digit slot rate.
  - SCAN_DIVIDE = BOARD/SCAN clocks per slot; must be >= 2.
- BLINK_FREQUENCY_IN_HZ, 2, blink rate.
  - BLINK_DIVIDE = BOARD/(2*BLINK) clocks per blink half-period.

Ports:
- clk  input  1  board clock
- rst  input  1  reset, synchronous, active-high
- number  input  NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT  packed BCD; digit k at bits [4k+3:4k]
- blink_mask  input  NUMBER_OF_DIGITS  1 = digit k blinks
- enable  input  1  1 = display on
- an  output  NUMBER_OF_DIGITS  anodes, active-low, registered
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- frame_start  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- One clock (clk). All state resets synchronously while rst=1.
- Reset values:
  - Scan prescaler, blink prescaler, digit index, blink_phase, shadow number, shadow mask: all 0.
  - load_pending = 1.
  - an = all ones, seg = 7'h7F, frame_start = 0.
- Scan prescaler: counts 0..SCAN_DIVIDE-1 and wraps. scan_tick = 1 when count == SCAN_DIVIDE-1.
- Digit index: advances on scan_tick; N-1 wraps to 0.
- Snapshot:
  - Load shadow number and shadow mask when load_pending=1, or on the scan_tick that wraps the index N-1 -> 0.
  - frame_start pulses in that same cycle. load_pending clears on that load.
  - The first cycle after rst deasserts therefore loads and pulses.
- Blink prescaler: counts 0..BLINK_DIVIDE-1; blink_phase toggles at terminal count. It is free-running and independent of scan.
- Digit k is blanked when any of these holds:
  - enable = 0;
  - shadow_mask[k] = 1 and blink_phase = 1;
  - leading-zero rule (see Optional Feature).
- Output latency: an/seg are registered and reflect the current index and shadow one cycle after they change.
  - Not blanked: an has only bit[index] low; seg = decode(shadow digit).
  - Blanked: an = all ones, seg = 7'h7F.
- Decode ({g..a}, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Values 10-15 display dash = 3F.
- enable=0: prescalers, index, snapshot and frame_start keep running; only the outputs are blanked.
- Input changes mid-frame are invisible until the next frame_start.
- rst mid-frame: next cycle outputs are at their reset values, then the scan restarts at digit 0 with a fresh snapshot.
- At most one anode is low in any cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k >= 1) is blanked when shadow digits N-1..k are all zero.
  - Digit 0 is never blanked by this rule.
  - The rule is evaluated on the shadow copy.
- Undefined: every digit is displayed, including leading zeros.

Test Plan:
Bench parameters: BOARD=1000, SCAN=100 (10 clk/slot, 40 clk/frame), BLINK=25 (20 clk half-period).
- Scan order: rst 3 cycles -> an=1111, seg=7F. Release with number=16'h1234, enable=1 -> frame_start on first cycle; slot 0 an=1110 seg=19; after 10 clk an=1101 seg=30; then 1011/24; then 0111/79; repeats every 40 clk.
- Frame coherence: number changes 16'h1234->16'h5678 during slot 1 -> slots 2,3 still show 24, 79; next frame shows 00, 78, 02, 12.
- Blink: blink_mask=4'b0001 -> slot 0 shows an=1110 seg=19 while blink_phase=0, and an=1111 seg=7F while blink_phase=1 (alternating 20-clk halves); slots 1-3 unaffected.
- Decode/enable: digit 0 = 4'hA -> seg=3F. enable=0 -> an=1111, seg=7F continuously while frame_start still pulses every 40 clk.
- Reset mid-frame: rst during slot 2 -> next cycle an=1111 seg=7F; after release, frame_start on the first cycle and scan restarts at slot 0.
- LEADING_ZERO_BLANK_EN:
  - number=16'h0005 -> slots 3,2,1 an=1111; slot 0 seg=12.
  - number=16'h0000 -> slot 0 seg=40.
  - Macro undefined -> 16'h0005 shows 40, 40, 40, 12.
